// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-access pipeline stage between EX/MEM and MEM/WB.
// Issues byte/halfword/word loads and stores over a req/ack data-memory bus,
// stalls upstream while a request is outstanding, raises a bus error after
// TIMEOUT unacknowledged cycles and tracks the LL/SC reservation.
// The write-back port is fully registered.
module mem_stage_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [5:0]        op,
    input  logic [REG_AW-1:0] regcAddr,
    input  logic              regcWr,
    input  logic [31:0]       regcData,
    input  logic [ADDR_W-1:0] memAddr_i,
    input  logic [31:0]       memData,
    input  logic              flush,
    output logic              stall_req,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic [REG_AW-1:0] regAddr,
    output logic              regWr,
    output logic [31:0]       regData,
    output logic              exc_align,
    output logic              exc_bus
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LL  = 6'b110000;
    localparam logic [5:0] OP_SC  = 6'b111000;

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state;
    logic              llbit;
    logic [ADDR_W-3:0] link_addr;
    logic [CNT_W-1:0]  cnt;

    // request context captured when the access is accepted
    logic [5:0]        op_p1;
    logic [1:0]        lane_p1;
    logic [REG_AW-1:0] dest_p1;
    logic              wr_p1;
    logic              flushed_p1;

    function automatic logic is_byte_op(input logic [5:0] o);
        return (o == OP_LB) || (o == OP_LBU) || (o == OP_SB);
    endfunction

    function automatic logic is_half_op(input logic [5:0] o);
        return (o == OP_LH) || (o == OP_LHU) || (o == OP_SH);
    endfunction

    function automatic logic is_word_op(input logic [5:0] o);
        return (o == OP_LW) || (o == OP_SW) || (o == OP_LL) || (o == OP_SC);
    endfunction

    function automatic logic is_store_op(input logic [5:0] o);
        return (o == OP_SB) || (o == OP_SH) || (o == OP_SW) || (o == OP_SC);
    endfunction

    function automatic logic [3:0] byte_en(input logic [5:0] o, input logic [1:0] lane);
        if (is_byte_op(o))
            return 4'b0001 << lane;
        else if (is_half_op(o))
            return 4'b0011 << lane;
        else
            return 4'b1111;
    endfunction

    // Narrow stores are replicated on every lane; the byte enables pick the target.
    function automatic logic [31:0] store_data(input logic [5:0] o, input logic [31:0] d);
        if (o == OP_SB)
            return {4{d[7:0]}};
        else if (o == OP_SH)
            return {2{d[15:0]}};
        else
            return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [5:0] o, input logic [1:0] lane,
                                                 input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {lane, 3'b000};
        case (o)
            OP_LB:   return {{24{sh[7]}}, sh[7:0]};
            OP_LBU:  return {24'b0, sh[7:0]};
            OP_LH:   return {{16{sh[15]}}, sh[15:0]};
            OP_LHU:  return {16'b0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    logic [ADDR_W-3:0] word_in;
    logic              is_mem;
    logic              misaligned;
    logic              sc_fail;
    logic              take;
    logic              start;
    logic              timed_out;
    logic              killed;

    assign word_in    = memAddr_i[ADDR_W-1:2];
    assign is_mem     = is_byte_op(op) | is_half_op(op) | is_word_op(op);
    assign misaligned = (is_word_op(op) && (memAddr_i[1:0] != 2'b00)) ||
                        (is_half_op(op) && memAddr_i[0]);
    assign sc_fail    = (op == OP_SC) && (!llbit || (word_in != link_addr));
    // a flush in the accept cycle discards the entry outright
    assign take       = (state == S_IDLE) && in_valid && !flush;
    assign start      = take && is_mem && !misaligned && !sc_fail;
    assign timed_out  = (state == S_WAIT) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));
    // a flush at any point of the transfer (including the final cycle) kills the write-back
    assign killed     = flushed_p1 | flush;

    // Upstream hold: combinational in the accept cycle, released in the ack/timeout cycle.
    assign stall_req  = rst && (start || ((state == S_WAIT) && !mem_ack && !timed_out));

    // Stage FSM, bus request registers, LL/SC reservation and registered write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            llbit      <= 1'b0;
            link_addr  <= '0;
            cnt        <= '0;
            op_p1      <= '0;
            lane_p1    <= '0;
            dest_p1    <= '0;
            wr_p1      <= 1'b0;
            flushed_p1 <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            regAddr    <= '0;
            regWr      <= 1'b0;
            regData    <= '0;
            exc_align  <= 1'b0;
            exc_bus    <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            exc_align <= 1'b0;
            exc_bus   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        if (!is_mem) begin
                            wb_valid <= 1'b1;
                            regAddr  <= regcAddr;
                            regWr    <= regcWr;
                            regData  <= regcData;
                        end else if (misaligned) begin
                            wb_valid  <= 1'b1;
                            regAddr   <= regcAddr;
                            regWr     <= 1'b0;
                            regData   <= '0;
                            exc_align <= 1'b1;
                        end else if (sc_fail) begin
                            wb_valid <= 1'b1;
                            regAddr  <= regcAddr;
                            regWr    <= regcWr;
                            regData  <= '0;
                            llbit    <= 1'b0;
                        end else begin
                            state      <= S_WAIT;
                            cnt        <= '0;
                            op_p1      <= op;
                            lane_p1    <= memAddr_i[1:0];
                            dest_p1    <= regcAddr;
                            wr_p1      <= regcWr;
                            flushed_p1 <= 1'b0;
                            mem_req    <= 1'b1;
                            mem_we     <= is_store_op(op);
                            mem_be     <= byte_en(op, memAddr_i[1:0]);
                            mem_addr   <= {word_in, 2'b00};
                            mem_wdata  <= store_data(op, memData);
                        end
                    end
                end
                S_WAIT: begin
                    if (flush)
                        flushed_p1 <= 1'b1;
                    if (mem_ack) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wb_valid <= 1'b1;
                        regAddr  <= dest_p1;
                        if (op_p1 == OP_SC) begin
                            regWr   <= wr_p1 & ~killed;
                            regData <= 32'd1;
                            llbit   <= 1'b0;
                        end else if (is_store_op(op_p1)) begin
                            regWr   <= 1'b0;
                            regData <= '0;
                            if (mem_addr[ADDR_W-1:2] == link_addr)
                                llbit <= 1'b0;
                        end else begin
                            regWr   <= wr_p1 & ~killed;
                            regData <= load_extract(op_p1, lane_p1, mem_rdata);
                            if (op_p1 == OP_LL) begin
                                llbit     <= 1'b1;
                                link_addr <= mem_addr[ADDR_W-1:2];
                            end
                        end
                    end else if (timed_out) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wb_valid <= 1'b1;
                        regAddr  <= dest_p1;
                        regWr    <= 1'b0;
                        regData  <= '0;
                        exc_bus  <= ~killed;
                        llbit    <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
            // flush always wins over any reservation update in the same cycle
            if (flush)
                llbit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed transactions for mem_stage_ctrl, with a
// transaction-level reference model and a per-cycle output comparator.
module tb_mem_stage_ctrl;

    localparam int ADDR_W  = 32;
    localparam int REG_AW  = 5;
    localparam int TIMEOUT = 16;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LL  = 6'b110000;
    localparam logic [5:0] OP_SC  = 6'b111000;
    localparam logic [5:0] OP_ADD = 6'b000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid;
    logic [5:0]        op;
    logic [REG_AW-1:0] regcAddr;
    logic              regcWr;
    logic [31:0]       regcData;
    logic [ADDR_W-1:0] memAddr_i;
    logic [31:0]       memData;
    logic              flush;
    logic              stall_req;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic              wb_valid;
    logic [REG_AW-1:0] regAddr;
    logic              regWr;
    logic [31:0]       regData;
    logic              exc_align;
    logic              exc_bus;

    mem_stage_ctrl #(.ADDR_W(ADDR_W), .REG_AW(REG_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op),
        .regcAddr(regcAddr), .regcWr(regcWr), .regcData(regcData),
        .memAddr_i(memAddr_i), .memData(memData), .flush(flush),
        .stall_req(stall_req), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .regAddr(regAddr), .regWr(regWr), .regData(regData),
        .exc_align(exc_align), .exc_bus(exc_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // expected outputs for the current cycle, set by the stimulus after each edge
    bit          chk_en = 1'b0;
    bit          e_stall_chk = 1'b1;
    logic        e_stall = 1'b0;
    logic        e_req = 1'b0;
    logic        e_we = 1'b0;
    logic [3:0]  e_be = '0;
    logic [31:0] e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic        e_wb = 1'b0;
    logic [4:0]  e_raddr = '0;
    logic        e_rwr = 1'b0;
    bit          e_rd_chk = 1'b0;
    logic [31:0] e_rdata = '0;
    logic        e_ea = 1'b0;
    logic        e_eb = 1'b0;

    int          tot_stall = 0;
    int          tot_req = 0;
    logic [31:0] last_wb_data = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_be = '0;

    // reservation model
    bit          m_ll = 1'b0;
    logic [31:0] m_link = '0;

    // Per-cycle comparator, sampling on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (e_stall_chk)
                chk("stall_req", stall_req, e_stall);
            if (stall_req === 1'b1) tot_stall++;
            if (mem_req === 1'b1) begin
                tot_req++;
                last_be    = mem_be;
                last_wdata = mem_wdata;
            end
            chk("mem_req", mem_req, e_req);
            if (e_req) begin
                chk("mem_we", mem_we, e_we);
                chk("mem_be", mem_be, e_be);
                chk("mem_addr", mem_addr, e_addr);
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
            chk("wb_valid", wb_valid, e_wb);
            if (e_wb) begin
                chk("regAddr", regAddr, e_raddr);
                chk("regWr", regWr, e_rwr);
                if (e_rd_chk) chk("regData", regData, e_rdata);
                last_wb_data = regData;
            end
            chk("exc_align", exc_align, e_ea);
            chk("exc_bus", exc_bus, e_eb);
        end
    end

    function automatic int op_size(input logic [5:0] o);
        case (o)
            OP_LB, OP_LBU, OP_SB:       return 1;
            OP_LH, OP_LHU, OP_SH:       return 2;
            OP_LW, OP_SW, OP_LL, OP_SC: return 4;
            default:                    return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [5:0] o);
        return (o == OP_SB) || (o == OP_SH) || (o == OP_SW) || (o == OP_SC);
    endfunction

    // value of the loaded field, interpreted as signed for Lb/Lh
    function automatic logic [31:0] m_load(input logic [5:0] o, input int lane, input logic [31:0] rd);
        longint v, full;
        int bits;
        bits = 8 * op_size(o);
        full = longint'(1) << bits;
        v = longint'(rd >> (8 * lane)) % full;
        if (((o == OP_LB) || (o == OP_LH)) && (v >= full / 2))
            v = v - full;
        return v[31:0];
    endfunction

    task automatic clear_exp();
        e_stall_chk = 1'b1; e_stall = 1'b0; e_req = 1'b0; e_wb = 1'b0;
        e_ea = 1'b0; e_eb = 1'b0; e_rd_chk = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        clear_exp();
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic flush_pulse();
        in_valid = 1'b0; flush = 1'b1;
        clear_exp();
        @(posedge clk); #1;
        flush = 1'b0;
        m_ll = 1'b0;
    endtask

    // One complete transaction. ack_at: WAIT cycle (1-based) carrying mem_ack, 0 = never.
    // flush_at: -1 none, 0 with in_valid, k = during WAIT cycle k.
    task automatic txn(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] dst, input logic wr, input int ack_at,
                       input logic [31:0] rd, input int flush_at);
        int  sz, lane;
        bit  mis, scf, acc, acked, killed, fl_last;
        sz   = op_size(o);
        lane = int'(a[1:0]);
        mis  = (sz != 0) && ((a % sz) != 0);
        scf  = (o == OP_SC) && !(m_ll && ((a >> 2) == m_link));
        acc  = (sz != 0) && !mis && !scf;
        in_valid = 1'b1; op = o; memAddr_i = a; memData = d; regcData = d;
        regcAddr = dst; regcWr = wr; flush = (flush_at == 0);
        clear_exp();
        e_stall = acc && (flush_at != 0);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; op = OP_ADD;
        if (flush_at == 0) begin
            m_ll = 1'b0;
            e_stall = 1'b0;
            @(posedge clk); #1;
            return;
        end
        if (!acc) begin
            if (!mis && scf) m_ll = 1'b0;
            e_stall = 1'b0; e_wb = 1'b1; e_raddr = dst;
            if (sz == 0) begin
                e_rwr = wr; e_rdata = d; e_rd_chk = 1'b1;
            end else if (mis) begin
                e_rwr = 1'b0; e_ea = 1'b1;
            end else begin
                e_rwr = wr; e_rdata = 32'd0; e_rd_chk = 1'b1;
            end
            @(posedge clk); #1;
            clear_exp();
            return;
        end
        e_req = 1'b1; e_we = op_store(o);
        e_be = 4'(((1 << sz) - 1) << lane);
        e_addr = a & ~32'h3;
        if (sz == 1)      e_wdata = {24'b0, d[7:0]} * 32'h01010101;
        else if (sz == 2) e_wdata = {16'b0, d[15:0]} * 32'h00010001;
        else              e_wdata = d;
        acked = 1'b0; killed = 1'b0; fl_last = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            acked   = (k == ack_at);
            mem_ack = acked;
            mem_rdata = acked ? rd : 32'hDEADBEEF;
            flush   = (k == flush_at);
            if (flush) begin
                killed = 1'b1; m_ll = 1'b0;
            end
            fl_last     = flush;
            e_stall_chk = acked || (k < TIMEOUT);
            e_stall     = !acked;
            @(posedge clk); #1;
            mem_ack = 1'b0; flush = 1'b0;
            if (acked) break;
        end
        clear_exp();
        e_wb = 1'b1; e_raddr = dst;
        if (acked) begin
            if (o == OP_SC) begin
                e_rwr = wr && !killed; e_rdata = 32'd1; e_rd_chk = 1'b1;
                m_ll = 1'b0;
            end else if (op_store(o)) begin
                e_rwr = 1'b0;
                if ((a >> 2) == m_link) m_ll = 1'b0;
            end else begin
                e_rwr = wr && !killed; e_rdata = m_load(o, lane, rd); e_rd_chk = 1'b1;
                if (o == OP_LL) begin
                    m_ll = 1'b1; m_link = a >> 2;
                end
            end
            if (fl_last) m_ll = 1'b0;
        end else begin
            e_rwr = 1'b0; e_eb = !killed; m_ll = 1'b0;
        end
        @(posedge clk); #1;
        clear_exp();
    endtask

    int base_req;
    int base_stall;

    initial begin
        rst = 1'b0; in_valid = 1'b0; op = OP_ADD; regcAddr = '0; regcWr = 1'b0;
        regcData = '0; memAddr_i = '0; memData = '0; flush = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0;
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_regData", regData, 0);
        chk("rst_mem_be", mem_be, 0);
        @(negedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_exp();
        chk_en = 1'b1;

        // non-memory op, latency 1
        txn(OP_ADD, 32'h0, 32'h12345678, 5'd4, 1'b1, 0, 32'h0, -1);
        chk("alu_lit", last_wb_data, 32'h12345678);

        // sized loads with sign/zero extension
        base_stall = tot_stall;
        txn(OP_LB, 32'h103, 32'h0, 5'd5, 1'b1, 4, 32'h80AA55CC, -1);
        chk("lb_lit", last_wb_data, 32'hFFFFFF80);
        chk("lb_be_lit", last_be, 4'b1000);
        chk("lb_stall_cycles", tot_stall - base_stall, 4);
        txn(OP_LBU, 32'h103, 32'h0, 5'd5, 1'b1, 4, 32'h80AA55CC, -1);
        chk("lbu_lit", last_wb_data, 32'h00000080);
        txn(OP_LH, 32'h102, 32'h0, 5'd6, 1'b1, 1, 32'h80AA55CC, -1);
        chk("lh_lit", last_wb_data, 32'hFFFF80AA);
        txn(OP_LHU, 32'h100, 32'h0, 5'd6, 1'b1, 2, 32'h80AA55CC, -1);
        chk("lhu_lit", last_wb_data, 32'h000055CC);

        // stores
        txn(OP_SH, 32'h202, 32'h1234ABCD, 5'd7, 1'b1, 2, 32'h0, -1);
        chk("sh_be_lit", last_be, 4'b1100);
        chk("sh_wdata_lit", last_wdata, 32'hABCDABCD);
        txn(OP_SB, 32'h301, 32'h000000EF, 5'd7, 1'b1, 1, 32'h0, -1);
        chk("sb_be_lit", last_be, 4'b0010);
        chk("sb_wdata_lit", last_wdata, 32'hEFEFEFEF);

        // LL/SC success, then a repeated Sc fails without a request
        txn(OP_LL, 32'h40, 32'h0, 5'd8, 1'b1, 1, 32'h00000077, -1);
        txn(OP_SC, 32'h40, 32'h7, 5'd9, 1'b1, 2, 32'h0, -1);
        chk("sc_ok_lit", last_wb_data, 32'd1);
        base_req = tot_req;
        txn(OP_SC, 32'h40, 32'h7, 5'd9, 1'b1, 1, 32'h0, -1);
        chk("sc_again_lit", last_wb_data, 32'd0);
        chk("sc_again_noreq", tot_req - base_req, 0);

        // intervening store to the linked word breaks the reservation
        txn(OP_LL, 32'h40, 32'h0, 5'd8, 1'b1, 1, 32'h1, -1);
        txn(OP_SW, 32'h40, 32'h55, 5'd0, 1'b0, 1, 32'h0, -1);
        base_req = tot_req;
        txn(OP_SC, 32'h40, 32'h7, 5'd9, 1'b1, 1, 32'h0, -1);
        chk("sc_after_sw_noreq", tot_req - base_req, 0);

        // flush breaks the reservation
        txn(OP_LL, 32'h40, 32'h0, 5'd8, 1'b1, 1, 32'h1, -1);
        flush_pulse();
        txn(OP_SC, 32'h40, 32'h7, 5'd9, 1'b1, 1, 32'h0, -1);

        // flush coincident with an Ll ack: write-back killed, no reservation
        txn(OP_LL, 32'h80, 32'h0, 5'd8, 1'b1, 2, 32'h2, 2);
        txn(OP_SC, 32'h80, 32'h7, 5'd9, 1'b1, 1, 32'h0, -1);

        // misalignment
        base_req = tot_req;
        txn(OP_LW, 32'h41, 32'h0, 5'd10, 1'b1, 1, 32'h0, -1);
        txn(OP_LH, 32'h101, 32'h0, 5'd10, 1'b1, 1, 32'h0, -1);
        chk("misaligned_noreq", tot_req - base_req, 0);

        // bus timeout
        base_req = tot_req;
        txn(OP_LW, 32'h44, 32'h0, 5'd11, 1'b1, 0, 32'h0, -1);
        chk("timeout_req_cycles", tot_req - base_req, TIMEOUT);

        // flush mid-transfer, then flush together with a new entry
        txn(OP_LW, 32'h48, 32'h0, 5'd12, 1'b1, 3, 32'hCAFEF00D, 2);
        txn(OP_LW, 32'h4C, 32'h0, 5'd12, 1'b1, 1, 32'h0, 0);
        idle(1);

        // reset in the middle of a transfer
        txn(OP_LL, 32'h40, 32'h0, 5'd8, 1'b1, 1, 32'h3, -1);
        in_valid = 1'b1; op = OP_LW; memAddr_i = 32'h60; regcAddr = 5'd13; regcWr = 1'b1;
        clear_exp(); e_stall = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = OP_ADD;
        e_req = 1'b1; e_we = 1'b0; e_be = 4'b1111; e_addr = 32'h60; e_stall = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b0;
        clear_exp();
        m_ll = 1'b0;
        #1;
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_stall", stall_req, 0);
        @(negedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        idle(3);
        base_req = tot_req;
        txn(OP_SC, 32'h40, 32'h7, 5'd9, 1'b1, 1, 32'h0, -1);
        chk("sc_after_rst_noreq", tot_req - base_req, 0);
        chk("sc_after_rst_lit", last_wb_data, 32'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
